mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter MAX_DM_BURST, default 4, the maximum consecutive data grants while a fetch is pending.
REQ-002 The module SHALL have parameter TIMEOUT, default 255, the maximum cycles to wait for mem_ack.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The module SHALL have ports if_req (in, 1), fetch request, and if_addr (in, 32), fetch address.
REQ-006 The module SHALL have ports if_ready (out, 1), fetch done pulse, and if_rdata (out, 32), fetched word.
REQ-007 The module SHALL have ports dm_req (in, 1), dm_we (in, 1), dm_addr (in, 32) and dm_wdata (in, 32), the MEM-stage load/store request.
REQ-008 The module SHALL have ports dm_ready (out, 1), data done pulse, and dm_rdata (out, 32), load data.
REQ-009 The module SHALL have ports mem_en (out, 1), mem_we (out, 1), mem_addr (out, 32) and mem_wdata (out, 32), the single-port unified memory command.
REQ-010 The module SHALL have ports mem_rdata (in, 32) and mem_ack (in, 1); mem_ack is a one-cycle completion pulse.
REQ-011 The module SHALL have port err (out, 1), a one-cycle pulse on timeout abort.

Function
REQ-012 The FSM SHALL have states IDLE, IF_BUSY, DM_BUSY and DONE.
REQ-013 In IDLE, with dm_req=1 and (if_req=0 or burst_cnt<MAX_DM_BURST), the FSM SHALL latch the dm_* inputs and go to DM_BUSY.
REQ-014 In IDLE, otherwise with if_req=1, the FSM SHALL latch if_addr and go to IF_BUSY.
REQ-015 On simultaneous if_req and dm_req, data SHALL win unless burst_cnt==MAX_DM_BURST, in which case fetch SHALL win.
REQ-016 burst_cnt SHALL increment on each data grant made while if_req=1, SHALL saturate at MAX_DM_BURST, and SHALL clear on every fetch grant.
REQ-017 In IF_BUSY and DM_BUSY, mem_en SHALL be 1 and mem_addr, mem_we and mem_wdata SHALL come from the latched request; mem_we SHALL always be 0 for fetch.
REQ-018 The memory command SHALL be registered: a grant in IDLE at cycle N SHALL drive mem_en in cycle N+1.
REQ-019 In a BUSY state, mem_ack=1 SHALL capture mem_rdata into the owner's rdata register and go to DONE.
REQ-020 DONE SHALL last one cycle with mem_en=0, pulse exactly the owner's ready, and return to IDLE.
REQ-021 Latency SHALL be k+2 cycles from grant to ready, for mem_ack arriving k cycles after mem_en rises (k>=0).
REQ-022 if_rdata and dm_rdata SHALL hold their last captured value until the next completion on that port; a store completion SHALL leave dm_rdata unchanged.
REQ-023 A 16-bit wait counter SHALL clear on entering BUSY and increment each BUSY cycle without mem_ack.
REQ-024 When the wait counter reaches TIMEOUT, the FSM SHALL go to DONE with owner rdata 0 and an err pulse together with ready.
REQ-025 mem_ack outside a BUSY state SHALL be ignored.
REQ-026 Requesters hold req and payload stable until ready; a req deasserted while not granted SHALL simply not be served.
REQ-027 A new grant SHALL NOT occur in DONE; the earliest re-grant is the IDLE cycle that follows.

Reset
REQ-028 reset SHALL asynchronously force state IDLE and burst_cnt=0, wait counter=0.
REQ-029 reset SHALL asynchronously force mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, dm_ready=0, err=0, if_rdata=0 and dm_rdata=0.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction with no ready pulse; a late mem_ack after reset SHALL be ignored per REQ-025.

Structure
REQ-031 The state encoding and the default MAX_DM_BURST and TIMEOUT values SHALL live in the shared package mips_pkg.
REQ-032 A single sub-module, arb_wait_counter, SHALL implement the clearable timeout counter; all other logic stays flat.

Verification
REQ-033 With if_req=1, if_addr=0x40 and mem_ack at k=2 returning 0x8C220004, the bench SHALL see mem_en for 3 cycles, mem_we=0, and if_ready with if_rdata=0x8C220004 4 cycles after grant.
REQ-034 With simultaneous if_req and a dm_req store to 0x100 of 0xDEADBEEF, the bench SHALL see a DM grant first, mem_we=1, dm_ready, then the IF grant.
REQ-035 With dm_req held continuously, if_req=1 and MAX_DM_BURST=4, the bench SHALL see exactly 4 data grants and then a fetch grant.
REQ-036 With no mem_ack and TIMEOUT=8, the bench SHALL see ready and err pulse together after 8 BUSY cycles with rdata=0.
REQ-037 With reset asserted in DM_BUSY and mem_ack the next cycle, the bench SHALL see all outputs 0, state IDLE and no dm_ready.
REQ-038 With mem_ack=1 while in IDLE, the bench SHALL see no ready and no state change.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM encoding and default limits.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    localparam int MAX_DM_BURST_DEFAULT = 4;
    localparam int TIMEOUT_DEFAULT      = 255;
    localparam int WAIT_CNT_W           = 16;

endpackage

// File: rtl/arb_wait_counter.sv
// Clearable wait counter used to bound how long the arbiter waits for mem_ack.
module arb_wait_counter
    import mips_pkg::*;
#(
    parameter int W = WAIT_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    // Saturates rather than wrapping so a stuck count can never alias a small value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one single-port memory,
// favouring data accesses but bounding data bursts so a pending fetch cannot starve.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int MAX_DM_BURST = MAX_DM_BURST_DEFAULT,
    parameter int TIMEOUT      = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    localparam int BW = $clog2(MAX_DM_BURST + 1);
    localparam logic [BW-1:0]         BURST_MAX = BW'(MAX_DM_BURST);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

    arb_state_t          state_reg;
    logic [BW-1:0]       burst_cnt_reg;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                busy;
    logic                dm_win;
    logic                timeout;

    assign busy    = (state_reg == IF_BUSY) || (state_reg == DM_BUSY);
    assign dm_win  = dm_req && (!if_req || (burst_cnt_reg < BURST_MAX));
    // The count reaches TIMEOUT on the edge that ends the TIMEOUT-th ack-less busy cycle.
    assign timeout = (wait_cnt == WAIT_LAST);

    arb_wait_counter #(
        .W(WAIT_CNT_W)
    ) u_wait_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (state_reg == IDLE),
        .inc   (busy && !mem_ack),
        .count (wait_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            burst_cnt_reg <= '0;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            if_ready      <= 1'b0;
            dm_ready      <= 1'b0;
            err           <= 1'b0;
            if_rdata      <= '0;
            dm_rdata      <= '0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            err      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (dm_win) begin
                        state_reg <= DM_BUSY;
                        mem_en    <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        // Only bursts that hold off a waiting fetch are counted.
                        if (if_req && (burst_cnt_reg < BURST_MAX)) begin
                            burst_cnt_reg <= burst_cnt_reg + 1'b1;
                        end
                    end else if (if_req) begin
                        state_reg     <= IF_BUSY;
                        mem_en        <= 1'b1;
                        mem_we        <= 1'b0;
                        mem_addr      <= if_addr;
                        mem_wdata     <= '0;
                        burst_cnt_reg <= '0;
                    end
                end
                IF_BUSY, DM_BUSY: begin
                    if (mem_ack || timeout) begin
                        state_reg <= DONE;
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        err       <= !mem_ack;
                        if (state_reg == IF_BUSY) begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata : '0;
                        end else begin
                            dm_ready <= 1'b1;
                            if (!mem_ack) begin
                                dm_rdata <= '0;
                            end else if (!mem_we) begin
                                dm_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
